// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with relative branch, jump, call/return stack, stall and sticky fault
// Optional feature macro: PCU_LIMIT_EN (refuse any update whose next PC exceeds PC_LIMIT)
module pc_unit #(
  parameter int             W        = 8,
  parameter int             DEPTH    = 4,
  parameter logic [W-1:0]   RESET_PC = '0,
  parameter logic [W-1:0]   PC_LIMIT = {W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [W-1:0]               offset,
  input  logic [W-1:0]               target,
  output logic [W-1:0]               pc,
  output logic [W-1:0]               pc_update,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       fault
);

  localparam int SPW   = $clog2(DEPTH + 1);
  // Index width is at least one bit so a single-entry stack still has a legal index.
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RAS_N = 1 << IW;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HOLD = 3'b101;

  logic [W-1:0]  ras [RAS_N];
  logic [W-1:0]  inc;
  logic [W-1:0]  nxt;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          push;
  logic          pop;
  logic          err;
  logic          advance;

  assign inc         = pc + W'(1);
  assign stack_full  = (sp == SPW'(DEPTH));
  assign stack_empty = (sp == '0);
  // sp is 1..DEPTH whenever a pop is legal, so the low bits minus one land on the top entry.
  assign wr_idx      = sp[IW-1:0];
  assign rd_idx      = wr_idx - IW'(1);
  assign advance     = en && !fault;
  assign pc_update   = fault ? pc : nxt;

  // Resolve the operation into a candidate next PC, stack action and error condition.
  always_comb begin
    nxt  = inc;
    push = 1'b0;
    pop  = 1'b0;
    err  = 1'b0;
    case (op)
      OP_SEQ: nxt = inc;
      OP_BR:  nxt = inc + offset;
      OP_JMP: nxt = target;
      OP_CALL: begin
        if (stack_full) begin
          nxt = pc;
          err = 1'b1;
        end else begin
          nxt  = target;
          push = 1'b1;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          nxt = pc;
          err = 1'b1;
        end else begin
          nxt = ras[rd_idx];
          pop = 1'b1;
        end
      end
      OP_HOLD: nxt = pc;
      default: nxt = inc;
    endcase
`ifdef PCU_LIMIT_EN
    if (!err && (nxt > PC_LIMIT)) begin
      nxt  = pc;
      err  = 1'b1;
      push = 1'b0;
      pop  = 1'b0;
    end
`endif
  end

  // PC, stack pointer and sticky fault; reset wins, a set fault freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      sp    <= '0;
      fault <= 1'b0;
    end else if (advance) begin
      if (err) begin
        fault <= 1'b1;
      end else begin
        pc <= nxt;
        if (push) begin
          sp <= sp + SPW'(1);
        end else if (pop) begin
          sp <= sp - SPW'(1);
        end
      end
    end
  end

  // Return-address storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (!rst && advance && push) begin
      ras[wr_idx] <= inc;
    end
  end

endmodule
